// File: rtl/rv_alu_pkg.sv
// Opcode encoding shared by the elastic-pipeline ALU and its datapath core.
// Stage payload structs live in rv_alu_pipe because their widths follow its parameters.
package rv_alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

endpackage

// File: rtl/rv_alu_core.sv
// Combinational RV32I/RV64I integer datapath: decodes the opcode and produces the result.
// Unassigned opcodes give a zero result and raise o_illegal.
module rv_alu_core
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic [XLEN-1:0]     i_a,
  input  logic [XLEN-1:0]     i_b,
  output logic [XLEN-1:0]     o_result,
  output logic                o_illegal
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] w_shamt;

  assign w_shamt = i_b[SH_W-1:0];

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_OR:    o_result = i_a | i_b;
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SRL:   o_result = i_a >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
      ALU_PASSB: o_result = i_b;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_alu_pipe.sv
// Elastic valid/ready integer ALU pipeline: S1 captures operands, S2 captures the result,
// S3..SN are pure delay. Bubbles collapse, flush kills everything in flight.
module rv_alu_pipe
  import rv_alu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 5,
  parameter int PIPE_STAGES = 2,
  localparam int CNT_W      = $clog2(PIPE_STAGES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                alu_op_valid,
  output logic                alu_rdy,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     alu_in1,
  input  logic [XLEN-1:0]     alu_in2,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic                alu_reg_mem_n,
  input  logic                alu_flush,
  output logic [XLEN-1:0]     alu_result,
  output logic                alu_result_valid,
  input  logic                alu_result_rdy,
  output logic [ADDR_W-1:0]   alu_result_addr,
  output logic                alu_result_reg_memn,
  output logic                alu_result_illegal,
  output logic [CNT_W-1:0]    alu_inflight
);

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [XLEN-1:0]     in1;
    logic [XLEN-1:0]     in2;
    logic [ADDR_W-1:0]   addr;
    logic                reg_memn;
  } opnd_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [ADDR_W-1:0] addr;
    logic              reg_memn;
    logic              illegal;
  } res_t;

  logic [PIPE_STAGES:1] r_v;
  logic [PIPE_STAGES:1] w_v_nxt;
  logic [PIPE_STAGES:1] w_adv;
  logic                 w_accept;
  logic                 w_pop;
  opnd_t                r_s1;
  res_t                 r_res [2:PIPE_STAGES];
  res_t                 w_s2_in;
  logic [XLEN-1:0]      w_core_result;
  logic                 w_core_illegal;
  logic [CNT_W-1:0]     r_inflight;

  // alu_rdy depends combinationally on alu_result_rdy through the advance chain.
  assign alu_rdy  = w_adv[1] & ~alu_flush & reset_n;
  assign w_accept = alu_op_valid & alu_rdy;
  assign w_pop    = r_v[PIPE_STAGES] & alu_result_rdy;

  generate
    for (genvar g = 1; g <= PIPE_STAGES; g++) begin : g_stage
      if (g == PIPE_STAGES) begin : g_last
        assign w_adv[g] = ~r_v[g] | alu_result_rdy;
      end else begin : g_mid
        assign w_adv[g] = ~r_v[g] | w_adv[g+1];
      end
      if (g == 1) begin : g_first
        assign w_v_nxt[g] = w_adv[g] ? w_accept : r_v[g];
      end else begin : g_follow
        assign w_v_nxt[g] = w_adv[g] ? r_v[g-1] : r_v[g];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v        <= '0;
      r_inflight <= '0;
    end else if (alu_flush) begin
      r_v        <= '0;
      r_inflight <= '0;
    end else begin
      r_v        <= w_v_nxt;
      r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_pop);
    end
  end

  rv_alu_core #(
    .XLEN(XLEN)
  ) u_core (
    .i_op     (r_s1.op),
    .i_a      (r_s1.in1),
    .i_b      (r_s1.in2),
    .o_result (w_core_result),
    .o_illegal(w_core_illegal)
  );

  assign w_s2_in = '{result: w_core_result, addr: r_s1.addr,
                     reg_memn: r_s1.reg_memn, illegal: w_core_illegal};

  // Payloads are qualified by r_v, so they load on advance without a reset.
  always_ff @(posedge clk) begin
    if (w_adv[1]) r_s1 <= '{op: alu_op, in1: alu_in1, in2: alu_in2,
                            addr: alu_addr, reg_memn: alu_reg_mem_n};
    if (w_adv[2]) r_res[2] <= w_s2_in;
    for (int i = 3; i <= PIPE_STAGES; i++) begin
      if (w_adv[i]) r_res[i] <= r_res[i-1];
    end
  end

  assign alu_result_valid    = r_v[PIPE_STAGES];
  assign alu_result          = r_v[PIPE_STAGES] ? r_res[PIPE_STAGES].result   : '0;
  assign alu_result_addr     = r_v[PIPE_STAGES] ? r_res[PIPE_STAGES].addr     : '0;
  assign alu_result_reg_memn = r_v[PIPE_STAGES] & r_res[PIPE_STAGES].reg_memn;
  assign alu_result_illegal  = r_v[PIPE_STAGES] & r_res[PIPE_STAGES].illegal;
  assign alu_inflight        = r_inflight;

endmodule
